// File: rtl/pc_redirect_pkg.sv
// Shared encodings for the PC redirect unit: request/selection enums and error-flag bit positions.
// Also hosts the branch condition evaluation so the top level stays focused on sequencing.
package pc_redirect_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BGT  = 3'd3,
    BR_BLT  = 3'd4
  } branch_sel_t;

  typedef enum logic [1:0] {
    JMP_NONE = 2'd0,
    JMP_JI   = 2'd1,
    JMP_JR   = 2'd2,
    JMP_RET  = 2'd3
  } jmp_sel_t;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'b00,
    SEL_JUMP   = 2'b01,
    SEL_RET    = 2'b10,
    SEL_BRANCH = 2'b11
  } next_sel_t;

  localparam int ERR_W       = 3;
  localparam int ERR_ILLEGAL = 2;
  localparam int ERR_RAS_OVF = 1;
  localparam int ERR_RAS_UNF = 0;

  // BLT has no dedicated flag: "less than" is neither greater nor equal.
  function automatic logic branch_taken(input logic [2:0] sel, input logic eq, input logic gt);
    logic t;
    t = 1'b0;
    case (sel)
      BR_BEQ:  t = eq;
      BR_BNE:  t = ~eq;
      BR_BGT:  t = gt;
      BR_BLT:  t = ~gt & ~eq;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/pc_redirect_unit_ras_stack.sv
// Return-address stack as a circular LIFO; a push when full overwrites the oldest entry.
// Pop on empty is ignored here; the caller decides the fallback target.
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full,
  output logic         overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] top_idx;

  // ptr_q is the next write slot; once full it also points at the oldest entry.
  assign top_idx  = ptr_q - PTR_W'(1);
  assign top      = mem_q[top_idx];
  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == (PTR_W+1)'(DEPTH));
  assign overflow = push & full;

  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[ptr_q] = push_dat;
      ptr_d        = ptr_q + PTR_W'(1);
      if (!full) begin
        cnt_d = cnt_q + (PTR_W+1)'(1);
      end
    end else if (pop && !empty) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/pc_redirect_unit.sv
// Program counter owner: picks sequential/branch/jump/return successor, drives a counted flush and sticky errors.
// Selection and taken are combinational from the execute request; pc and flush are registered.
module pc_redirect_unit
  import pc_redirect_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter int                INSTR_BYTES  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0,
  parameter int                FLUSH_CYCLES = 2,
  parameter int                RAS_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              valid,
  input  logic [2:0]        branch_sel,
  input  logic              eq,
  input  logic              gt,
  input  logic [1:0]        jmp_sel,
  input  logic              call,
  input  logic [ADDR_W-1:0] target_b,
  input  logic [ADDR_W-1:0] target_i,
  input  logic [ADDR_W-1:0] target_r,
  output logic [ADDR_W-1:0] pc,
  output logic [1:0]        next_sel,
  output logic              taken,
  output logic              flush,
  output logic [2:0]        err
);

  localparam int              CNT_W      = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              flush_q, flush_d;
  logic [ERR_W-1:0]  err_q, err_d;

  logic              accept;
  logic              illegal;
  jmp_sel_t          jsel;
  next_sel_t         sel;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] target;
  logic              ras_push, ras_pop, ras_unf;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty, ras_full, ras_overflow;

  // rst_n gates acceptance so the combinational outputs read SEQ during reset.
  assign accept  = rst_n & valid & ~stall & ~flush_q;
  assign illegal = ((branch_sel != BR_NONE) && (jmp_sel != JMP_NONE)) || (branch_sel > BR_BLT);
  assign jsel    = jmp_sel_t'(jmp_sel);
  assign seq_pc  = pc_q + ADDR_W'(INSTR_BYTES);

  always_comb begin
    sel      = SEL_SEQ;
    target   = seq_pc;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    ras_unf  = 1'b0;
    if (accept && !illegal) begin
      case (jsel)
        JMP_JI: begin
          sel      = SEL_JUMP;
          target   = target_i;
          ras_push = call;
        end
        JMP_JR: begin
          sel      = SEL_JUMP;
          target   = target_r;
          ras_push = call;
        end
        JMP_RET: begin
          sel = SEL_RET;
          if (ras_empty) begin
            target  = target_r;
            ras_unf = 1'b1;
          end else begin
            target  = ras_top;
            ras_pop = 1'b1;
          end
        end
        default: begin
          if (branch_taken(branch_sel, eq, gt)) begin
            sel    = SEL_BRANCH;
            target = target_b;
          end
        end
      endcase
    end
  end

  assign taken    = (sel != SEL_SEQ);
  assign next_sel = sel;

  always_comb begin
    pc_d = pc_q;
    if (taken) begin
      pc_d = target;
    end else if (!stall) begin
      pc_d = seq_pc;
    end
  end

  // Counter freezes under stall so the flush window counts only cycles that advance.
  always_comb begin
    cnt_d = cnt_q;
    if (taken) begin
      cnt_d = FLUSH_LOAD;
    end else if (!stall && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    flush_d = (cnt_d != '0);
  end

  always_comb begin
    err_d              = err_q;
    err_d[ERR_ILLEGAL] = err_q[ERR_ILLEGAL] | (accept & illegal);
    err_d[ERR_RAS_OVF] = err_q[ERR_RAS_OVF] | (ras_overflow & ras_full);
    err_d[ERR_RAS_UNF] = err_q[ERR_RAS_UNF] | ras_unf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      flush_q <= 1'b0;
      err_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      err_q   <= err_d;
    end
  end

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (ADDR_W)
  ) u_ras (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (ras_push),
    .push_dat (seq_pc),
    .pop      (ras_pop),
    .top      (ras_top),
    .empty    (ras_empty),
    .full     (ras_full),
    .overflow (ras_overflow)
  );

  assign pc    = pc_q;
  assign flush = flush_q;
  assign err   = err_q;

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Parametrised successor to the processor's next-instruction-select decode.
- Owns the program counter register and resolves sequential, conditional-branch, immediate-jump, register-jump and return redirects.
- Adds a return-address stack (RAS), a stall input and a counted pipeline-flush output.
- Sits in processor/control between the execute-stage flag and target outputs and the fetch stage.

Parameters:
- ADDR_W, 32, PC and target address width.
- INSTR_BYTES, 4, sequential PC increment.
- RESET_PC, 0, PC value on reset.
- FLUSH_CYCLES, 2, cycles `flush` stays high after a redirect; 0 disables flushing.
- RAS_DEPTH, 4, return-address stack entries; power of two, at least 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- stall  in  1  hold PC; no request is accepted
- valid  in  1  resolve request from execute this cycle
- branch_sel  in  3  branch type: NONE=0, BEQ=1, BNE=2, BGT=3, BLT=4; 5-7 illegal
- eq  in  1  ALU equal flag
- gt  in  1  ALU greater-than flag
- jmp_sel  in  2  jump type: NONE=0, JI=1, JR=2, RET=3
- call  in  1  with JI/JR, push the return address
- target_b  in  ADDR_W  branch target
- target_i  in  ADDR_W  immediate jump target
- target_r  in  ADDR_W  register jump target; also the RET fallback
- pc  out  ADDR_W  current PC, registered
- next_sel  out  2  SEQ=00, JUMP=01, RET=10, BRANCH=11; combinational
- taken  out  1  redirect accepted this cycle; combinational
- flush  out  1  squash younger pipeline stages; registered
- err  out  3  sticky flags {illegal, ras_ovf, ras_unf}

Behaviour:
- Reset (asynchronous, any time, including mid-flush or with a full RAS):
  - pc=RESET_PC, flush=0, flush counter=0, RAS pointer and count=0, err=0.
  - Combinational outputs settle to SEQ and taken=0 while rst_n is low.
- Acceptance: a request is accepted when valid & !stall & !flush. Otherwise next_sel=SEQ and taken=0.
- Condition codes:
  - BEQ is taken when eq.
  - BNE is taken when !eq.
  - BGT is taken when gt.
  - BLT is taken when !gt & !eq.
- Illegal requests: branch_sel nonzero with jmp_sel nonzero, or branch_sel 5-7.
  - Treated as SEQ.
  - err[2] is set.
  - No RAS change.
- Selection of an accepted request:
  - JI: next_sel=JUMP, target=target_i.
  - JR: next_sel=JUMP, target=target_r.
  - RET: next_sel=RET, target=RAS top.
  - Taken branch: next_sel=BRANCH, target=target_b.
  - Otherwise: SEQ.
  - taken=1 for every selection other than SEQ.
- PC update at the rising edge:
  - stall: pc holds.
  - taken: pc<=target.
  - Otherwise: pc<=pc+INSTR_BYTES, modulo 2^ADDR_W, wrapping silently.
- Flush:
  - An accepted taken request loads the counter with FLUSH_CYCLES.
  - flush = (counter != 0), registered, so it rises the cycle after the redirect.
  - The counter decrements once per non-stalled cycle and freezes while stall=1.
  - valid requests while flush=1 are discarded.
- RAS push: call together with accepted JI/JR pushes pc+INSTR_BYTES.
  - Circular buffer.
  - Push when full overwrites the oldest entry and sets err[1]; count stays RAS_DEPTH.
- RAS pop: accepted RET pops.
  - If empty, target=target_r and err[0] is set.
  - call with RET or with a branch is ignored.
  - call with no jump is ignored.
- Sticky err bits clear only on reset.

Decomposition:
- Package pc_redirect_pkg:
  - branch_sel_t, jmp_sel_t and next_sel_t enums with the encodings above.
  - ERR_* bit index constants.
- One sub-module, ras_stack: parametrised circular LIFO with push, pop, top, empty, full and overflow outputs.
- Counter, PC register and selection logic stay in the top level.

Test Plan:
- Reset and sequential fetch: release rst_n with RESET_PC=0x100, no valid for 3 cycles -> pc=0x100, 0x104, 0x108, 0x10C; flush=0; err=0.
- Conditional branches:
  - pc=0x200, BEQ with eq=1 and target_b=0x400 -> same cycle next_sel=11, taken=1.
  - Next cycle pc=0x400, flush=1 for 2 cycles.
  - A valid JI during the flush is ignored and pc continues 0x404, 0x408.
  - BLT with eq=1, gt=0 -> not taken.
- Call/return with wrap:
  - JI+call at pc=0x10 to 0x80 -> pc becomes 0x80.
  - Five further JI+call requests -> err[1]=1.
  - Four RET requests return the four newest addresses in LIFO order.
  - A fifth RET with target_r=0x3C -> pc=0x3C, err[0]=1.
- Stall interaction: stall=1 during a taken JR to 0x500 -> pc holds, taken=0.
  - Release stall with the request still valid -> redirect to 0x500.
  - stall=1 mid-flush freezes the counter, so flush stays high 2 unstalled cycles total.
- Illegal and reset: branch_sel=BEQ with jmp_sel=JI -> SEQ, err[2]=1.
  - Assert rst_n low mid-flush -> pc=RESET_PC, flush=0, err=0 immediately, without waiting for a clock edge.
